// File: rtl/bf16_mul_pipe.sv
// Three-stage, valid/ready handshaked bfloat16 multiplier.
// Stage 1 unpacks and classifies the operands and forms the sign and the exponent sum.
// Stage 2 multiplies the significands.
// Stage 3 normalizes, rounds, packs and reports errors.
// A stall at the output holds every stage in place.
module bf16_mul_pipe #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ERROR_WIDTH = 2,
  parameter int unsigned TAG_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in1,
  input  logic [DATA_WIDTH-1:0]  in2,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out,
  output logic [ERROR_WIDTH-1:0] error,
  output logic [TAG_WIDTH-1:0]   out_tag
);

  localparam logic [ERROR_WIDTH-1:0] ErrNone = ERROR_WIDTH'(0);
  localparam logic [ERROR_WIDTH-1:0] ErrOvf  = ERROR_WIDTH'(1);
  localparam logic [ERROR_WIDTH-1:0] ErrUnf  = ERROR_WIDTH'(2);
  localparam logic [ERROR_WIDTH-1:0] ErrInv  = ERROR_WIDTH'(3);

  // Result class decided in stage 1; only KNorm needs the arithmetic path.
  typedef enum logic [1:0] {KNorm, KZero, KInf, KNan} kind_e;

  logic stall;

  // Stage 1 registers
  logic                  s1_valid;
  logic                  s1_sign;
  kind_e                 s1_kind;
  logic signed [9:0]     s1_exp;
  logic [7:0]            s1_sig_a;
  logic [7:0]            s1_sig_b;
  logic [TAG_WIDTH-1:0]  s1_tag;

  // Stage 2 registers
  logic                  s2_valid;
  logic                  s2_sign;
  kind_e                 s2_kind;
  logic signed [9:0]     s2_exp;
  logic [15:0]           s2_prod;
  logic [TAG_WIDTH-1:0]  s2_tag;

  // Stage 1 combinational
  logic                  sign_a, sign_b;
  logic [7:0]            exp_a, exp_b;
  logic [6:0]            man_a, man_b;
  logic                  nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  kind_e                 kind_d;
  logic signed [9:0]     exp_sum_d;

  // Stage 3 combinational
  logic                  norm;
  logic [6:0]            mant;
  logic                  guard, sticky, round_up;
  logic [7:0]            mant_rnd;
  logic signed [9:0]     exp_fin;
  logic [DATA_WIDTH-1:0] res_d;
  logic [ERROR_WIDTH-1:0] err_d;

  // Handshake: the whole pipe freezes while the consumer refuses a valid result.
  always_comb begin
    stall    = out_valid && !out_ready;
    in_ready = rst_n && !stall;
  end

  // Stage 1: unpack, classify, sign and biased exponent sum.
  always_comb begin
    sign_a = in1[15];
    exp_a  = in1[14:7];
    man_a  = in1[6:0];
    sign_b = in2[15];
    exp_b  = in2[14:7];
    man_b  = in2[6:0];
    nan_a  = (exp_a == 8'hFF) && (man_a != 7'd0);
    nan_b  = (exp_b == 8'hFF) && (man_b != 7'd0);
    inf_a  = (exp_a == 8'hFF) && (man_a == 7'd0);
    inf_b  = (exp_b == 8'hFF) && (man_b == 7'd0);
    // Subnormals flush to zero.
    zero_a = (exp_a == 8'd0);
    zero_b = (exp_b == 8'd0);
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
      kind_d = KNan;
    end else if (inf_a || inf_b) begin
      kind_d = KInf;
    end else if (zero_a || zero_b) begin
      kind_d = KZero;
    end else begin
      kind_d = KNorm;
    end
    exp_sum_d = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
  end

  // Stage 3: normalize by at most one bit, round to nearest even, range-check, pack.
  always_comb begin
    norm = s2_prod[15];
    if (norm) begin
      mant   = s2_prod[14:8];
      guard  = s2_prod[7];
      sticky = |s2_prod[6:0];
    end else begin
      mant   = s2_prod[13:7];
      guard  = s2_prod[6];
      sticky = |s2_prod[5:0];
    end
    round_up = guard && (sticky || mant[0]);
    mant_rnd = {1'b0, mant} + {7'd0, round_up};
    // A rounding carry leaves mant_rnd[6:0] at zero and bumps the exponent.
    exp_fin  = s2_exp + $signed({9'd0, norm}) + $signed({9'd0, mant_rnd[7]});
    res_d    = '0;
    err_d    = ErrNone;
    unique case (s2_kind)
      KNan: begin
        res_d = 16'h7FC0;
        err_d = ErrInv;
      end
      KInf: begin
        res_d = {s2_sign, 8'hFF, 7'd0};
      end
      KZero: begin
        res_d = {s2_sign, 15'd0};
      end
      KNorm: begin
        if (exp_fin >= 10'sd255) begin
          res_d = {s2_sign, 8'hFF, 7'd0};
          err_d = ErrOvf;
        end else if (exp_fin <= 10'sd0) begin
          res_d = {s2_sign, 15'd0};
          err_d = ErrUnf;
        end else begin
          res_d = {s2_sign, exp_fin[7:0], mant_rnd[6:0]};
        end
      end
    endcase
  end

  // Pipeline registers: synchronous reset, hold on stall, bubbles advance as invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_kind   <= KNorm;
      s1_exp    <= '0;
      s1_sig_a  <= '0;
      s1_sig_b  <= '0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_kind   <= KNorm;
      s2_exp    <= '0;
      s2_prod   <= '0;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      error     <= '0;
      out_tag   <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        // NaN results always carry a positive sign.
        s1_sign  <= (kind_d == KNan) ? 1'b0 : (sign_a ^ sign_b);
        s1_kind  <= kind_d;
        s1_exp   <= exp_sum_d;
        s1_sig_a <= {1'b1, man_a};
        s1_sig_b <= {1'b1, man_b};
        s1_tag   <= in_tag;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_kind <= s1_kind;
        s2_exp  <= s1_exp;
        s2_prod <= s1_sig_a * s1_sig_b;
        s2_tag  <= s1_tag;
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        out     <= res_d;
        error   <= err_d;
        out_tag <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// Self-checking bench for bf16_mul_pipe: a vector table with hand-derived products, a
// scoreboard queue of expected results, and hand sequences for backpressure, throughput
// and mid-operation reset.
module tb_bf16_mul_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1, in2;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [1:0]  error;
  logic [3:0]  out_tag;

  bf16_mul_pipe #(
    .DATA_WIDTH (16),
    .ERROR_WIDTH(2),
    .TAG_WIDTH  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .error    (error),
    .out_tag  (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] o;
    logic [1:0]  e;
  } vec_t;

  localparam int NVec = 23;
  vec_t tbl [NVec];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc;
  int rd_ptr = 0;

  // Written only by the output monitor.
  int          act_cnt = 0;
  logic [21:0] act_mem [0:127];
  int          act_cyc [0:127];

  logic [21:0] exp_q [$];

  // Free-running cycle count used to time acceptances and results.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every result that is transferred at the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && act_cnt < 128) begin
      act_mem[act_cnt] <= {out, error, out_tag};
      act_cyc[act_cnt] <= cyc;
      act_cnt          <= act_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Present one pair from posedge+1 until it is accepted; queue its expected result.
  task automatic offer(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                       input logic [15:0] eo, input logic [1:0] ee);
    int   waited;
    logic done;
    waited   = 0;
    done     = 1'b0;
    in_valid = 1'b1;
    in1      = a;
    in2      = b;
    in_tag   = t;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({eo, ee, t});
        acc_cyc = cyc;
        done    = 1'b1;
      end else if (waited >= 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: tag %0h not accepted in %0d cycles", t, waited);
        done = 1'b1;
      end
      waited++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for every queued expectation to be matched by a captured result.
  task automatic drain();
    int          b;
    logic [21:0] e;
    logic [21:0] a;
    b = 0;
    while ((act_cnt - rd_ptr) < exp_q.size() && b < 100) begin
      @(posedge clk);
      #1;
      b++;
    end
    if ((act_cnt - rd_ptr) < exp_q.size()) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results, want %0d", act_cnt - rd_ptr, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_ptr < act_cnt) begin
      e = exp_q.pop_front();
      a = act_mem[rd_ptr];
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL result[%0d]: got out=%h err=%b tag=%h, want out=%h err=%b tag=%h",
                 rd_ptr, a[21:6], a[5:4], a[3:0], e[21:6], e[5:4], e[3:0]);
      end
      rd_ptr++;
    end
    exp_q.delete();
  endtask

  initial begin
    int nacc;
    int base;
    int acc0;
    int cnt0;

    tbl[0]  = '{16'h3FC0, 16'h4000, 16'h4040, 2'b00};
    tbl[1]  = '{16'hBF80, 16'h4040, 16'hC040, 2'b00};
    tbl[2]  = '{16'h7F80, 16'h0000, 16'h7FC0, 2'b11};
    tbl[3]  = '{16'h7F00, 16'h7F00, 16'h7F80, 2'b01};
    tbl[4]  = '{16'h0080, 16'h0080, 16'h0000, 2'b10};
    tbl[5]  = '{16'h7FC1, 16'h3F80, 16'h7FC0, 2'b11};
    tbl[6]  = '{16'h3F81, 16'h3F81, 16'h3F82, 2'b00};
    tbl[7]  = '{16'h3F80, 16'h3F80, 16'h3F80, 2'b00};
    tbl[8]  = '{16'h4000, 16'h4000, 16'h4080, 2'b00};
    tbl[9]  = '{16'hFF80, 16'h3F80, 16'hFF80, 2'b00};
    tbl[10] = '{16'h7F80, 16'hC000, 16'hFF80, 2'b00};
    tbl[11] = '{16'h8000, 16'h4000, 16'h8000, 2'b00};
    tbl[12] = '{16'h0001, 16'h7F80, 16'h7FC0, 2'b11};  // subnormal is zero: Inf x 0
    tbl[13] = '{16'h0000, 16'hFFC0, 16'h7FC0, 2'b11};
    tbl[14] = '{16'h3FC0, 16'h3F81, 16'h3FC2, 2'b00};  // exact tie, rounds up to even
    tbl[15] = '{16'h3FC0, 16'h3F83, 16'h3FC4, 2'b00};  // exact tie, stays even
    tbl[16] = '{16'h3F92, 16'h3FE0, 16'h4000, 2'b00};  // rounding carries into exponent
    tbl[17] = '{16'h7F12, 16'h3FE0, 16'h7F80, 2'b01};  // overflow only after rounding
    tbl[18] = '{16'h0080, 16'h3F80, 16'h0080, 2'b00};  // smallest normal survives
    tbl[19] = '{16'h8080, 16'h3F00, 16'h8000, 2'b10};  // exponent 0: signed underflow
    tbl[20] = '{16'h7F7F, 16'h3F80, 16'h7F7F, 2'b00};  // largest finite
    tbl[21] = '{16'hFF80, 16'h8000, 16'h7FC0, 2'b11};
    tbl[22] = '{16'hC000, 16'hC000, 16'h4080, 2'b00};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic product and latency
    base = rd_ptr;
    offer(16'h3FC0, 16'h4000, 4'd3, 16'h4040, 2'b00);
    acc0 = acc_cyc;
    drain();
    chk("latency", 32'(act_cyc[base] - acc0), 32'd3);

    // Vector table, streamed back to back
    for (int i = 0; i < NVec; i++) begin
      offer(tbl[i].a, tbl[i].b, 4'(i), tbl[i].o, tbl[i].e);
    end
    drain();

    // Backpressure: consumer stalled while five pairs are offered
    out_ready = 1'b0;
    nacc      = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (nacc < 5);
      in1      = 16'h3F80 + (16'(nacc) << 7);
      in2      = 16'h4000;
      in_tag   = 4'(nacc);
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'(c < 3));
      if (c >= 3) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_tag", 32'(out_tag), 32'd0);
        chk("bp_hold_out", 32'(out), 32'h4000);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({16'h4000 + (16'(nacc) << 7), 2'b00, 4'(nacc)});
        nacc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(nacc), 32'd3);
    out_ready = 1'b1;
    for (int k = 3; k < 5; k++) begin
      offer(16'h3F80 + (16'(k) << 7), 16'h4000, 4'(k), 16'h4000 + (16'(k) << 7), 2'b00);
    end
    drain();

    // Throughput: ten pairs, ten results on consecutive cycles
    base = rd_ptr;
    acc0 = 0;
    for (int k = 0; k < 10; k++) begin
      offer(16'h3F80 + (16'(k) << 7), 16'h4000, 4'(k), 16'h4000 + (16'(k) << 7), 2'b00);
      if (k == 0) acc0 = acc_cyc;
    end
    drain();
    for (int k = 0; k < 10; k++) begin
      chk("tput_cycle", 32'(act_cyc[base+k] - acc0), 32'(3 + k));
    end

    // Nothing arrived beyond what was expected
    repeat (5) @(posedge clk);
    #1;
    chk("no_extra_results", 32'(act_cnt), 32'(rd_ptr));

    // Mid-operation reset discards in-flight pairs
    offer(16'h4000, 16'h4000, 4'd7, 16'h4080, 2'b00);
    offer(16'h3FC0, 16'h4000, 4'd8, 16'h4040, 2'b00);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out", 32'(out), 32'd0);
    chk("mrst_error", 32'(error), 32'd0);
    chk("mrst_out_tag", 32'(out_tag), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    cnt0 = act_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("mrst_no_stale", 32'(act_cnt), 32'(cnt0));
    chk("mrst_idle_valid", 32'(out_valid), 32'd0);

    // Pipe still works after the reset
    offer(16'hBF80, 16'h4040, 4'd9, 16'hC040, 2'b01 ^ 2'b01);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/bf16_mul_pipe.md
Name: bf16_mul_pipe

Overview:
- Pipelined, handshaked bfloat16 multiplier with the same operand/result/error encoding as the combinational multiplier.
- It is the responder side of the operand-request / result-response stream. The stimulus sequencer drives operand pairs in; the block returns one result per accepted pair, in order.
- Sits between the vector sequencer and the result capture logic. Throughput is one operation per cycle, with full backpressure.

Parameters:
- DATA_WIDTH, 16, operand/result width (bfloat16: 1 sign, 8 exponent, 7 mantissa, bias 127); fixed at 16.
- ERROR_WIDTH, 2, error code width.
- TAG_WIDTH, 4, opaque tag width, passed through unchanged with each operation.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept a pair this cycle.
- in1  input  DATA_WIDTH  operand A.
- in2  input  DATA_WIDTH  operand B.
- in_tag  input  TAG_WIDTH  request tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  DATA_WIDTH  product.
- error  output  ERROR_WIDTH  00 none, 01 overflow, 10 underflow, 11 invalid.
- out_tag  output  TAG_WIDTH  tag of the returned result.

Behaviour:
- **Reset** (rst_n low at a rising edge): all stage valids, out_valid, out, error and out_tag are cleared to 0. in_ready is 0 while rst_n is low. Reset mid-operation discards in-flight pairs without emitting them.
- **Pipeline:** 3 registered stages.
  - S1: unpack, classify, sign XOR, exponent sum.
  - S2: 8x8 significand multiply.
  - S3: normalize, round, pack, error.
- **Latency:** 3 cycles from in_valid&&in_ready to out_valid, with no stall.
- **Handshake:**
  - Transfer occurs when valid&&ready are both high at a rising edge.
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational, gated by rst_n).
  - On stall, every stage holds. Otherwise all stages advance, and bubbles propagate as invalid.
  - in1/in2/in_tag are ignored when in_valid is 0.
  - out/error/out_tag are stable while out_valid && !out_ready.
  - Order is preserved; no result is lost or duplicated.
- **Arithmetic:**
  - Exponent 0 inputs (zero or subnormal) are treated as signed zero.
  - Significand is {1,mant}. The 16-bit product is normalized by at most 1 bit.
  - Round to nearest, ties to even, on the 7-bit mantissa. Round carry-out increments the exponent.
  - Overflow and underflow are checked after rounding.
- **Special cases** (first match wins):
  - Either operand NaN, or Inf×0: out=0x7FC0, error=11.
  - Either operand Inf (other nonzero): out = signed Inf (sign = XOR of input signs), error=00.
  - Either operand zero: signed zero, error=00.
  - Biased result exponent ≥255: signed Inf, error=01.
  - Biased result exponent ≤0: signed zero, error=10 (no subnormal output).
  - Otherwise: error=00.
- **Width rules:** exponent sum is computed in 10-bit signed form (eA+eB−127+norm) to detect both bounds. Sign is always the XOR of input signs, except for NaN (sign 0).

Test Plan:
- **Basic product:** reset low 2 cycles, then high; send in1=0x3FC0, in2=0x4000, tag=3 with out_ready=1 -> 3 cycles later out_valid=1, out=0x4040, error=00, out_tag=3. Send 0xBF80×0x4040 -> out=0xC040, error=00.
- **Specials:** send 0x7F80×0x0000 -> out=0x7FC0, error=11. Send 0x7F00×0x7F00 -> out=0x7F80, error=01. Send 0x0080×0x0080 -> out=0x0000, error=10. Send 0x7FC1×0x3F80 -> out=0x7FC0, error=11.
- **Rounding:** send 0x3F81×0x3F81 -> out=0x3F82, error=00.
- **Backpressure:** hold out_ready=0 and offer 5 pairs (tags 0–4) back to back.
  - in_ready is high until the first result reaches out_valid, then low. Exactly 3 pairs are accepted.
  - Output holds tag 0 stable.
  - Release out_ready -> tags 0–4 emerge in order, each exactly once.
- **Throughput:** stream 10 pairs with out_ready=1 -> 10 results on 10 consecutive cycles, starting 3 cycles after the first acceptance, with no bubbles.
- **Mid-operation reset:** accept 2 pairs, then assert rst_n=0 for 1 cycle -> out_valid=0 and out/error/out_tag=0 after that edge; no stale result emerges afterward.
